// File: rtl/lvds_tx_pll_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module   : lvds_tx_pll_ctrl_pkg
// Brief    : Shared state encoding and reset constants for the LVDS TX PLL
//            reset sequencer / lock supervisor.
// Revision : 1.0
//==============================================================================
package lvds_tx_pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        READY     = 3'd3,
        FAULT     = 3'd4
    } pll_state_t;

    localparam logic [3:0] PSDA_RST   = 4'b0000;
    localparam logic [3:0] DUTYDA_RST = 4'b1000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lvds_tx_pll_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module   : lvds_tx_pll_ctrl_if
// Brief    : Control, configuration and PLL-side signals of the LVDS TX PLL
//            controller. slave = controller view, master = system view.
// Revision : 1.0
//==============================================================================
interface lvds_tx_pll_ctrl_if;

    logic       pll_lock;
    logic       restart;
    logic       cfg_wr;
    logic [3:0] cfg_psda;
    logic [3:0] cfg_duty;

    logic       pll_reset;
    logic [3:0] psda;
    logic [3:0] dutyda;
    logic       tx_rst_n;
    logic       ready;
    logic       fault;
    logic       lost_lock;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    modport master (
        output pll_lock, restart, cfg_wr, cfg_psda, cfg_duty,
        input  pll_reset, psda, dutyda, tx_rst_n, ready, fault,
               lost_lock, retry_cnt, lock_loss_cnt
    );

    modport slave (
        input  pll_lock, restart, cfg_wr, cfg_psda, cfg_duty,
        output pll_reset, psda, dutyda, tx_rst_n, ready, fault,
               lost_lock, retry_cnt, lock_loss_cnt
    );

endinterface
`default_nettype wire

// File: rtl/lvds_pll_lock_sync.sv
`default_nettype none
//==============================================================================
// Module   : lvds_pll_lock_sync
// Brief    : Two-flop synchronizer bringing the PLL lock flag into clkin.
// Revision : 1.0
//==============================================================================
module lvds_pll_lock_sync (
    input  wire logic clkin,
    input  wire logic reset_n,
    input  wire logic i_async,
    output logic      o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/lvds_tx_pll_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : lvds_tx_pll_ctrl
// Brief    : PLL reset sequencer and lock supervisor; holds the serializer in
//            reset until lock is stable and owns the PSDA/DUTYDA settings.
// Revision : 1.0
//==============================================================================
module lvds_tx_pll_ctrl
    import lvds_tx_pll_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYC     = 64,
    parameter int LOCK_TIMEOUT_CYC = 70200,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRY        = 3,
    parameter int CNT_W            = 17
) (
    input  wire logic        clkin,
    input  wire logic        reset_n,
    lvds_tx_pll_ctrl_if.slave pll_if
);

    localparam logic [CNT_W-1:0] c_rst_last     = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [1:0]       c_max_retry    = 2'(MAX_RETRY);

    logic             w_lock_s;
    pll_state_t       r_state;
    pll_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_retry_cnt;
    logic [1:0]       w_retry_nxt;
    logic             w_loss_evt;
    logic             w_cnt_clr;
    logic             w_cnt_run;
    logic             r_lost_lock;
    logic [7:0]       r_lock_loss_cnt;
    logic             r_pll_reset;
    logic             r_tx_rst_n;
    logic             r_ready;
    logic             r_fault;
    logic [3:0]       r_psda;
    logic [3:0]       r_dutyda;

    lvds_pll_lock_sync u_lock_sync (
        .clkin   (clkin),
        .reset_n (reset_n),
        .i_async (pll_if.pll_lock),
        .o_sync  (w_lock_s)
    );

    // restart wins over every in-state event, including lock loss and timeout
    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry_cnt;
        w_loss_evt  = 1'b0;
        if (pll_if.restart) begin
            w_state_nxt = RST_PLL;
            w_retry_nxt = 2'd0;
        end else begin
            case (r_state)
                RST_PLL: begin
                    if (r_cnt == c_rst_last) w_state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nxt = STABLE;
                    end else if (r_cnt == c_timeout_last) begin
                        if (r_retry_cnt == c_max_retry) begin
                            w_state_nxt = FAULT;
                        end else begin
                            w_state_nxt = RST_PLL;
                            w_retry_nxt = r_retry_cnt + 2'd1;
                        end
                    end
                end
                STABLE: begin
                    if (!w_lock_s)                   w_state_nxt = WAIT_LOCK;
                    else if (r_cnt == c_stable_last) w_state_nxt = READY;
                end
                READY: begin
                    if (!w_lock_s) begin
                        w_state_nxt = RST_PLL;
                        w_retry_nxt = 2'd0;
                        w_loss_evt  = 1'b1;
                    end
                end
                FAULT:   w_state_nxt = FAULT;
                default: w_state_nxt = RST_PLL;
            endcase
        end
    end

    assign w_cnt_clr = pll_if.restart || (w_state_nxt != r_state);
    assign w_cnt_run = (r_state == RST_PLL) || (r_state == WAIT_LOCK) ||
                       (r_state == STABLE);

    // Outputs are decoded from the next state so they change on the same edge
    // as the state register they describe.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= RST_PLL;
            r_cnt           <= '0;
            r_retry_cnt     <= 2'd0;
            r_lost_lock     <= 1'b0;
            r_lock_loss_cnt <= 8'd0;
            r_pll_reset     <= 1'b1;
            r_tx_rst_n      <= 1'b0;
            r_ready         <= 1'b0;
            r_fault         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_lost_lock <= w_loss_evt;
            if (w_loss_evt) r_lock_loss_cnt <= sat_inc8(r_lock_loss_cnt);
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_run) r_cnt <= r_cnt + CNT_W'(1);
            r_pll_reset <= (w_state_nxt == RST_PLL) || (w_state_nxt == FAULT);
            r_tx_rst_n  <= (w_state_nxt == READY);
            r_ready     <= (w_state_nxt == READY);
            r_fault     <= (w_state_nxt == FAULT);
        end
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_psda   <= PSDA_RST;
            r_dutyda <= DUTYDA_RST;
        end else if (pll_if.cfg_wr) begin
            r_psda   <= pll_if.cfg_psda;
            r_dutyda <= pll_if.cfg_duty;
        end
    end

    assign pll_if.pll_reset     = r_pll_reset;
    assign pll_if.psda          = r_psda;
    assign pll_if.dutyda        = r_dutyda;
    assign pll_if.tx_rst_n      = r_tx_rst_n;
    assign pll_if.ready         = r_ready;
    assign pll_if.fault         = r_fault;
    assign pll_if.lost_lock     = r_lost_lock;
    assign pll_if.retry_cnt     = r_retry_cnt;
    assign pll_if.lock_loss_cnt = r_lock_loss_cnt;

endmodule
`default_nettype wire
